fifo_wr_ptr_full: RTL

- Write-side pointer and full-flag controller for the async FIFO, in the write clock domain.
- Sits directly upstream of the FIFO memory. Drives its write address and full inputs from the producer's write-increment.
- Synchronizes the read-domain Gray pointer internally. Exports its own Gray pointer to the read-side controller.
- Also provides fill level, almost-full and a sticky overflow flag.

---
 rtl/fifo_wr_ptr_full.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer, full/level/almost-full and sticky overflow logic for an async FIFO.
// Optional almost-full flag is built only when FIFO_WR_ALMOST_FULL_EN is defined.
module fifo_wr_ptr_full #(
  parameter int PTR_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic                 w_inc,
  input  logic [PTR_WIDTH-1:0] r_gray_ptr,
  input  logic                 w_ovf_clr,
  output logic [PTR_WIDTH-2:0] w_addr,
  output logic [PTR_WIDTH-1:0] w_gray_ptr,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [PTR_WIDTH-1:0] w_level,
  output logic                 w_ovf
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  logic [PTR_WIDTH-1:0] w_bin_reg;
  logic [PTR_WIDTH-1:0] w_gray_reg;
  logic [PTR_WIDTH-1:0] level_reg;
  logic                 full_reg;
  logic                 ovf_reg;

  logic [PTR_WIDTH-1:0] w_bin_next;
  logic [PTR_WIDTH-1:0] w_gray_next;
  logic [PTR_WIDTH-1:0] level_next;
  logic [PTR_WIDTH-1:0] full_gray;
  logic                 full_next;
  logic                 wr_en;

  logic [PTR_WIDTH-1:0] rq_gray;
  logic [PTR_WIDTH-1:0] rq_bin;

  // Read-pointer synchronizer: plain flop chain, nothing combinational ahead of stage 0.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [PTR_WIDTH-1:0] stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge w_clk or negedge w_rst_n) begin
          if (!w_rst_n) stage_reg <= '0;
          else          stage_reg <= r_gray_ptr;
        end
      end else begin : g_next
        always_ff @(posedge w_clk or negedge w_rst_n) begin
          if (!w_rst_n) stage_reg <= '0;
          else          stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign rq_gray = g_sync[SYNC_STAGES-1].stage_reg;

  generate
    for (genvar gi = 0; gi < PTR_WIDTH; gi++) begin : g_g2b
      assign rq_bin[gi] = ^rq_gray[PTR_WIDTH-1:gi];
    end
  endgenerate

  assign wr_en       = w_inc && !full_reg;
  assign w_bin_next  = w_bin_reg + {{(PTR_WIDTH-1){1'b0}}, wr_en};
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // Full when our next pointer is exactly one lap ahead of the synchronized read pointer.
  assign full_gray  = {~rq_gray[PTR_WIDTH-1:PTR_WIDTH-2], rq_gray[PTR_WIDTH-3:0]};
  assign full_next  = (w_gray_next == full_gray);
  assign level_next = w_bin_next - rq_bin;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_bin_reg  <= '0;
      w_gray_reg <= '0;
      full_reg   <= 1'b0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      w_bin_reg  <= w_bin_next;
      w_gray_reg <= w_gray_next;
      full_reg   <= full_next;
      level_reg  <= level_next;
      if (w_inc && full_reg) ovf_reg <= 1'b1;
      else if (w_ovf_clr)    ovf_reg <= 1'b0;
    end
  end

  assign w_addr     = w_bin_reg[ADDR_W-1:0];
  assign w_gray_ptr = w_gray_reg;
  assign w_full     = full_reg;
  assign w_level    = level_reg;
  assign w_ovf      = ovf_reg;

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(AF_THRESH);

  logic af_reg;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) af_reg <= 1'b0;
    else          af_reg <= (level_next >= AF_LEVEL);
  end

  assign w_almost_full = af_reg;
`else
  // Flag compiled out; the threshold is still referenced so the parameter set is build-independent.
  assign w_almost_full = 1'b0 && (AF_THRESH > 0);
`endif

endmodule
